sin_table_loader: RTL

//  Fills the 128x8 single-port sine sample RAM, the writer side of the table the sine generator reads.

---
 rtl/sin_pkg.sv | 16 +
 rtl/sum8_acc.sv | 26 ++
 rtl/sin_table_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sin_pkg.sv
// Shared widths and FSM state encoding for the sine table loader and its helpers.
package sin_pkg;

  localparam int SIN_ADDR_W = 7;
  localparam int SIN_DATA_W = 8;
  localparam int SIN_DEPTH  = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    CHECK,
    DONE
  } sin_state_t;

endpackage

// File: rtl/sum8_acc.sv
// Clearable wrap-around accumulator; carries out of the top bit are dropped.
module sum8_acc
  import sin_pkg::*;
#(
  parameter int W = SIN_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  // clear wins over en so a new run never inherits a stale partial sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/sin_table_loader.sv
// Streams DEPTH sample bytes into the sine RAM, reads the table back and
// compares the readback sum against the sum of the bytes that were written.
module sin_table_loader
  import sin_pkg::*;
#(
  parameter int ADDR_W = SIN_ADDR_W,
  parameter int DATA_W = SIN_DATA_W,
  parameter int DEPTH  = SIN_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  // One extra counter bit lets DEPTH == 2**ADDR_W finish without wrapping.
  localparam int            CW   = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  sin_state_t        state;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_cnt;
  logic              rd_pend;
  logic              beat;
  logic              accept;
  logic [DATA_W-1:0] load_sum;
  logic [DATA_W-1:0] rd_sum;
  logic [DATA_W-1:0] final_sum;

  assign beat      = in_valid & in_ready;
  assign accept    = (state == IDLE) & start;
  assign ram_we    = beat;
  assign ram_din   = (state == LOAD) ? in_data : '0;
  assign final_sum = rd_sum + ram_dout;

  always_comb begin
    ram_addr = '0;
    case (state)
      LOAD:    ram_addr = wr_cnt[ADDR_W-1:0];
      VERIFY:  ram_addr = rd_cnt[ADDR_W-1:0];
      CHECK:   ram_addr = LAST[ADDR_W-1:0];
      default: ram_addr = '0;
    endcase
  end

  sum8_acc #(.W(DATA_W)) u_load_sum (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (beat),
    .din   (in_data),
    .sum   (load_sum)
  );

  // The RAM answers one cycle late, so each read is summed on the following cycle.
  sum8_acc #(.W(DATA_W)) u_rd_sum (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    ((state == VERIFY) & rd_pend),
    .din   (ram_dout),
    .sum   (rd_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      rd_pend  <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      checksum <= '0;
    end else begin
      rd_pend <= (state == VERIFY);
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            wr_cnt   <= '0;
            error    <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (beat) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == LAST) begin
              state    <= VERIFY;
              rd_cnt   <= '0;
              in_ready <= 1'b0;
            end
          end
        end
        VERIFY: begin
          rd_cnt <= rd_cnt + CW'(1);
          if (rd_cnt == LAST) begin
            state <= CHECK;
          end
        end
        // The last read lands here, so it is folded in directly rather than accumulated.
        CHECK: begin
          error    <= (final_sum != load_sum);
          checksum <= load_sum;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
